isp_frame_sequencer: RTL and testbench

Frame-level controller for the ISP processing chain (demosaic -> filter -> rgb2ycc). It accepts a frame-start request, clears all stages, and admits exactly one frame of sensor pixels. It then waits for every stage to report done and reports frame completion. It replaces the per-stage "reset | oDone" self-restart with one central sequence, including timeout recovery.

---
 rtl/isp_frame_sequencer_if.sv | 40 ++++
 rtl/isp_frame_sequencer.sv | 154 +++++++++++++++
 tb/tb_isp_frame_sequencer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/isp_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// isp_frame_sequencer_if
// Groups the frame sequencer's control and status signals into one bundle.
//   iStart       frame-start request, one-cycle pulse
//   iValid       sensor pixel valid
//   oAccept      pixel admitted this cycle when iValid=1
//   iStageDone   per-stage done pulses (bit 0 = demosaic)
//   oStageReset  synchronous reset pulse to all stages
//   oBusy        sequencer not idle
//   oFrameDone   one-cycle frame completion pulse
//   oError       sticky drain-timeout flag
//   oPixCnt      pixels admitted in the current frame
//   oFrameCnt    completed frames (wraps)
// Modports: master drives requests and observes status (sensor side /
// system controller); slave is the sequencer itself.
// ---------------------------------------------------------------------------
interface isp_frame_sequencer_if #(
   parameter int NUM_STAGES = 3
);
   logic                  iStart;
   logic                  iValid;
   logic                  oAccept;
   logic [NUM_STAGES-1:0] iStageDone;
   logic [NUM_STAGES-1:0] oStageReset;
   logic                  oBusy;
   logic                  oFrameDone;
   logic                  oError;
   logic [31:0]           oPixCnt;
   logic [15:0]           oFrameCnt;

   modport master (
      output iStart, iValid, iStageDone,
      input  oAccept, oStageReset, oBusy, oFrameDone, oError, oPixCnt, oFrameCnt
   );

   modport slave (
      input  iStart, iValid, iStageDone,
      output oAccept, oStageReset, oBusy, oFrameDone, oError, oPixCnt, oFrameCnt
   );
endinterface

// File: rtl/isp_frame_sequencer.sv
// ---------------------------------------------------------------------------
// isp_frame_sequencer
// Central frame controller for the demosaic -> filter -> rgb2ycc chain.
// A start request clears every stage, exactly width*height pixels are
// admitted, then the sequencer waits for all stages to report done (or
// times out) before reporting completion and returning to idle.
// Ports:
//   clk      system clock, all state on the rising edge
//   reset_n  asynchronous active-low reset
//   bus      isp_frame_sequencer_if.slave (requests in, status out)
// ---------------------------------------------------------------------------
module isp_frame_sequencer #(
   parameter int width      = 320,
   parameter int height     = 240,
   parameter int NUM_STAGES = 3,
   parameter int TIMEOUT    = 1048576
) (
   input  logic                  clk,
   input  logic                  reset_n,
   isp_frame_sequencer_if.slave  bus
);

   localparam logic [31:0] FRAME_SIZE = 32'(width * height);
   // Counter only needs to reach TIMEOUT-1 before the FSM leaves DRAIN.
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
   localparam logic [NUM_STAGES-1:0] ALL_ONES = '1;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      RUN,
      DRAIN,
      DONE,
      ERROR
   } state_t;

   state_t                stateReg, stateNext;
   logic                  pendingReg, pendingNext;
   logic [31:0]           pixCntReg, pixCntNext;
   logic [15:0]           frameCntReg, frameCntNext;
   logic [NUM_STAGES-1:0] doneMaskReg, doneMaskNext;
   logic [TW-1:0]         timeoutReg, timeoutNext;
   logic                  errorReg, errorNext;

   logic                  accept;
   logic                  admit;
   logic [NUM_STAGES-1:0] mergedDone;

   assign accept     = (stateReg == RUN) && (pixCntReg < FRAME_SIZE);
   assign admit      = accept && bus.iValid;
   // Includes this cycle's pulses so a final done bit is acted on at once.
   assign mergedDone = doneMaskReg | bus.iStageDone;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stateReg    <= IDLE;
         pendingReg  <= 1'b0;
         pixCntReg   <= '0;
         frameCntReg <= '0;
         doneMaskReg <= '0;
         timeoutReg  <= '0;
         errorReg    <= 1'b0;
      end else begin
         stateReg    <= stateNext;
         pendingReg  <= pendingNext;
         pixCntReg   <= pixCntNext;
         frameCntReg <= frameCntNext;
         doneMaskReg <= doneMaskNext;
         timeoutReg  <= timeoutNext;
         errorReg    <= errorNext;
      end
   end

   // Next-state and datapath updates
   always_comb begin
      stateNext    = stateReg;
      pendingNext  = pendingReg;
      pixCntNext   = pixCntReg;
      frameCntNext = frameCntReg;
      doneMaskNext = doneMaskReg;
      timeoutNext  = timeoutReg;
      errorNext    = errorReg;

      // Requests arriving mid-frame are remembered one deep; a second one
      // while already pending simply leaves the flag set (dropped).
      if (bus.iStart && (stateReg != IDLE) && (stateReg != DONE)) begin
         pendingNext = 1'b1;
      end

      unique case (stateReg)
         IDLE: begin
            if (bus.iStart || pendingReg) begin
               stateNext   = CLEAR;
               pendingNext = 1'b0;
            end
         end
         CLEAR: begin
            pixCntNext   = '0;
            doneMaskNext = '0;
            timeoutNext  = '0;
            errorNext    = 1'b0;
            stateNext    = RUN;
         end
         RUN: begin
            doneMaskNext = mergedDone;
            if (admit) begin
               pixCntNext = pixCntReg + 32'd1;
               if (pixCntReg == FRAME_SIZE - 32'd1) begin
                  stateNext = DRAIN;
               end
            end
         end
         DRAIN: begin
            doneMaskNext = mergedDone;
            timeoutNext  = timeoutReg + TW'(1);
            if (mergedDone == ALL_ONES) begin
               stateNext = DONE;
            end else if (timeoutReg == TIMEOUT_LAST) begin
               stateNext = ERROR;
            end
         end
         DONE: begin
            frameCntNext = frameCntReg + 16'd1;
            // A request in this very cycle chains straight into the next frame.
            if (pendingReg || bus.iStart) begin
               stateNext   = CLEAR;
               pendingNext = 1'b0;
            end else begin
               stateNext = IDLE;
            end
         end
         ERROR: begin
            errorNext = 1'b1;
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Stage reset is also forced while the sequencer itself is held in reset.
   assign bus.oStageReset = (!reset_n || stateReg == CLEAR || stateReg == ERROR)
                            ? ALL_ONES : '0;
   assign bus.oAccept     = accept;
   assign bus.oBusy       = (stateReg != IDLE);
   assign bus.oFrameDone  = (stateReg == DONE);
   assign bus.oError      = errorReg;
   assign bus.oPixCnt     = pixCntReg;
   assign bus.oFrameCnt   = frameCntReg;

endmodule

// File: tb/tb_isp_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_isp_frame_sequencer
// Self-checking bench for isp_frame_sequencer (4x2 frame, 3 stages,
// timeout 16): a cycle table for the nominal frame, directed sequences for
// timeout, back-to-back, simultaneous done/timeout and async reset, then
// random frames checked against a frame-level outcome model.
// ---------------------------------------------------------------------------
module tb_isp_frame_sequencer;

   localparam int W  = 4;
   localparam int H  = 2;
   localparam int NS = 3;
   localparam int TO = 16;
   localparam int FS = W * H;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   isp_frame_sequencer_if #(.NUM_STAGES(NS)) bus ();

   isp_frame_sequencer #(
      .width(W), .height(H), .NUM_STAGES(NS), .TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus.slave)
   );

   int vectors = 0;
   int miscompares = 0;
   int admitted = 0;
   int expFc = 0;

   // Outputs sampled at the falling edge of the current cycle.
   logic        sAcc, sBusy, sFd, sErr;
   logic [2:0]  sSr;
   logic [31:0] sPix;
   logic [15:0] sFc;

   typedef struct {
      logic        s;
      logic        v;
      logic [2:0]  d;
      logic        acc;
      logic [2:0]  sr;
      logic        busy;
      logic        fd;
      logic        err;
      logic [31:0] pix;
      logic [15:0] fc;
   } vec_t;

   vec_t tbl[16];

   function automatic vec_t mk(input logic s, v, input logic [2:0] d,
                               input logic acc, input logic [2:0] sr,
                               input logic busy, fd, err,
                               input int pix, input int fc);
      vec_t r;
      r.s = s; r.v = v; r.d = d; r.acc = acc; r.sr = sr;
      r.busy = busy; r.fd = fd; r.err = err;
      r.pix = 32'(pix); r.fc = 16'(fc);
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Sample this cycle's outputs, then drive this cycle's inputs.
   task automatic step(input logic s, input logic v, input logic [2:0] d);
      @(negedge clk);
      sAcc  = bus.oAccept;
      sSr   = bus.oStageReset;
      sBusy = bus.oBusy;
      sFd   = bus.oFrameDone;
      sErr  = bus.oError;
      sPix  = bus.oPixCnt;
      sFc   = bus.oFrameCnt;
      bus.iStart     = s;
      bus.iValid     = v;
      bus.iStageDone = d;
      if (sAcc && v) admitted++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic       val[80];
      logic [2:0] dn[80];
      logic [2:0] miss;
      int cnt, lastPix, ds, endCyc, obsEnd;
      logic isDone, obsDone;
      logic [2:0] acc;

      // ---------------- reset state ----------------
      reset_n = 1'b0;
      bus.iStart = 1'b0; bus.iValid = 1'b0; bus.iStageDone = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs",
          {bus.oAccept, bus.oStageReset, bus.oBusy, bus.oFrameDone, bus.oError,
           bus.oPixCnt, bus.oFrameCnt},
          {1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0});
      reset_n = 1'b1;

      // ---------------- nominal frame, cycle table ----------------
      tbl[0] = mk(1, 0, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0);
      tbl[1] = mk(0, 1, 3'b000, 0, 3'b111, 1, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++)
         tbl[2 + i] = mk(0, 1, 3'b000, 1, 3'b000, 1, 0, 0, i, 0);
      tbl[10] = mk(0, 1, 3'b001, 0, 3'b000, 1, 0, 0, 8, 0);
      tbl[11] = mk(0, 0, 3'b010, 0, 3'b000, 1, 0, 0, 8, 0);
      tbl[12] = mk(0, 0, 3'b100, 0, 3'b000, 1, 0, 0, 8, 0);
      tbl[13] = mk(0, 0, 3'b000, 0, 3'b000, 1, 1, 0, 8, 0);
      tbl[14] = mk(0, 0, 3'b000, 0, 3'b000, 0, 0, 0, 8, 1);
      tbl[15] = mk(0, 0, 3'b000, 0, 3'b000, 0, 0, 0, 8, 1);
      admitted = 0;
      foreach (tbl[i]) begin
         step(tbl[i].s, tbl[i].v, tbl[i].d);
         chk($sformatf("nominal_cycle%0d", i),
             {sAcc, sSr, sBusy, sFd, sErr, sPix, sFc},
             {tbl[i].acc, tbl[i].sr, tbl[i].busy, tbl[i].fd, tbl[i].err, tbl[i].pix, tbl[i].fc});
      end
      chk("nominal_admitted", 64'(admitted), 64'(FS));
      expFc = 1;
      $display("nominal frame: %0d pixels admitted, frame count %0d", admitted, sFc);

      // ---------------- timeout: stage 2 never reports ----------------
      admitted = 0;
      step(1, 0, 3'b000);
      step(0, 0, 3'b000);
      chk("timeout_clear_reset", 64'(sSr), 64'(3'b111));
      for (int i = 0; i < 8; i++)
         step(0, 1, (i == 0) ? 3'b001 : (i == 1) ? 3'b010 : 3'b000);
      n = -1;
      for (int i = 0; i < 40; i++) begin
         step(0, 0, 3'b000);
         if (sSr == 3'b111) begin
            n = i;
            break;
         end
      end
      chk("timeout_drain_cycles", 64'(n), 64'(TO));
      step(0, 0, 3'b000);
      chk("timeout_error_idle", {sErr, sBusy, sFc}, {1'b1, 1'b0, 16'(expFc)});
      step(0, 0, 3'b000);
      chk("timeout_error_sticky", 64'(sErr), 64'd1);
      $display("timeout frame: error after %0d drain cycles", n);

      // ---------------- back-to-back with a dropped third request ----------------
      admitted = 0;
      step(1, 0, 3'b000);
      step(0, 0, 3'b000);
      chk("b2b_clear_holds_error", {sErr, sSr}, {1'b1, 3'b111});
      for (int i = 0; i < 8; i++)
         step((i == 0 || i == 2), 1, 3'b000);
      chk("b2b_error_cleared", 64'(sErr), 64'd0);
      step(0, 0, 3'b111);
      chk("b2b_drain", {sAcc, sPix, 32'(admitted)}, {1'b0, 32'(FS), 32'(FS)});
      step(0, 0, 3'b000);
      chk("b2b_done1", 64'(sFd), 64'd1);
      expFc++;
      admitted = 0;
      step(0, 0, 3'b000);
      chk("b2b_direct_clear", {sSr, sBusy}, {3'b111, 1'b1});
      for (int i = 0; i < 8; i++)
         step(0, 1, (i == 0) ? 3'b111 : 3'b000);
      step(0, 0, 3'b000);
      step(0, 0, 3'b000);
      chk("b2b_done2", 64'(sFd), 64'd1);
      expFc++;
      step(0, 0, 3'b000);
      chk("b2b_idle", {sBusy, sFc}, {1'b0, 16'(expFc)});
      step(0, 0, 3'b000);
      chk("b2b_third_dropped", {sBusy, sSr, 32'(admitted)}, {1'b0, 3'b000, 32'(FS)});
      $display("back-to-back: frame count %0d", sFc);

      // ---------------- done and timeout in the same cycle ----------------
      step(1, 0, 3'b000);
      step(0, 0, 3'b000);
      for (int i = 0; i < 8; i++)
         step(0, 1, (i == 0) ? 3'b011 : 3'b000);
      for (int i = 0; i < TO - 1; i++)
         step(0, 0, 3'b000);
      step(0, 0, 3'b100);
      step(0, 0, 3'b000);
      chk("simul_done_wins", {sFd, sSr}, {1'b1, 3'b000});
      expFc++;
      step(0, 0, 3'b000);
      chk("simul_idle", {sErr, sBusy, sFc}, {1'b0, 1'b0, 16'(expFc)});
      $display("simultaneous done/timeout: frame count %0d", sFc);

      // ---------------- asynchronous reset mid-frame ----------------
      admitted = 0;
      step(1, 0, 3'b000);
      step(0, 0, 3'b000);
      for (int i = 0; i < 5; i++)
         step(0, 1, 3'b000);
      chk("areset_admitted", 64'(admitted), 64'd5);
      #2 reset_n = 1'b0;
      #1;
      chk("areset_immediate",
          {bus.oAccept, bus.oStageReset, bus.oBusy, bus.oFrameDone, bus.oError,
           bus.oPixCnt, bus.oFrameCnt},
          {1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0});
      n = 0;
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 3'b000);
         if (sFd) n++;
      end
      chk("areset_no_frame_done", 64'(n), 64'd0);
      reset_n = 1'b1;
      expFc = 0;
      step(0, 0, 3'b000);
      chk("areset_release_idle", {sBusy, sAcc, sSr, sPix}, {1'b0, 1'b0, 3'b000, 32'd0});
      $display("async reset: outputs cleared, idle after release");

      // ---------------- random frames vs frame-level model ----------------
      for (int f = 0; f < 12; f++) begin
         miss = ($urandom_range(0, 3) == 0) ? (3'b001 << $urandom_range(0, 2)) : 3'b000;
         for (int k = 0; k < 80; k++) begin
            val[k] = (k >= 30) ? 1'b1 : ($urandom_range(0, 2) != 0);
            for (int b = 0; b < 3; b++)
               dn[k][b] = (k >= 2) && ($urandom_range(0, 7) == 0);
            dn[k] = dn[k] & ~miss;
         end

         // Model: the frameSize-th valid pixel after CLEAR ends admission;
         // completion needs the union of all done pulses since RUN began,
         // checked only from the first drain cycle, within TO drain cycles.
         cnt = 0; lastPix = -1;
         for (int k = 2; k < 80; k++) begin
            if (val[k] && cnt < FS) begin
               cnt++;
               if (cnt == FS) lastPix = k;
            end
         end
         ds = lastPix + 1;
         acc = 3'b000; isDone = 1'b0; endCyc = ds + TO;
         for (int k = 2; k < ds + TO; k++) begin
            acc = acc | dn[k];
            if (!isDone && k >= ds && acc == 3'b111) begin
               isDone = 1'b1;
               endCyc = k + 1;
            end
         end

         admitted = 0; obsEnd = -1; obsDone = 1'b0;
         step(1, 0, 3'b000);
         step(0, 0, 3'b000);
         for (int k = 2; k < 80; k++) begin
            step(0, val[k], dn[k]);
            if (sFd) begin
               obsEnd = k; obsDone = 1'b1;
               break;
            end
            if (sSr == 3'b111) begin
               obsEnd = k;
               break;
            end
         end
         chk($sformatf("rand%0d_outcome", f), {31'(obsEnd), obsDone}, {31'(endCyc), isDone});
         chk($sformatf("rand%0d_admitted", f), 64'(admitted), 64'(FS));
         if (isDone) expFc++;
         step(0, 0, 3'b000);
         chk($sformatf("rand%0d_idle", f), {sBusy, sErr, sPix, sFc},
             {1'b0, ~isDone, 32'(FS), 16'(expFc)});
         $display("random frame %0d: %s at cycle %0d (model %0d), frame count %0d",
                  f, obsDone ? "done" : "timeout", obsEnd, endCyc, sFc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
